// File: rtl/tone_synth.sv
// Tone synthesiser: phase accumulator + ADSR-style envelope -> square sample + PWM.
// Ports: clk_i, reset_i (sync, active-low), fstep_i (phase step, 0 = off),
//        sample_o/sample_valid_o (8-bit sample + update strobe), pwm_o, active_o.
module tone_synth #(
    parameter int unsigned SAMPLE_DIV_P   = 256,
    parameter int unsigned ATTACK_STEP_P  = 4,
    parameter int unsigned RELEASE_STEP_P = 2
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic [31:0] fstep_i,
    output logic [7:0]  sample_o,
    output logic        sample_valid_o,
    output logic        pwm_o,
    output logic        active_o
);

    localparam int unsigned DIV_W = $clog2(SAMPLE_DIV_P);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV_P - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ATTACK,
        ST_SUSTAIN,
        ST_RELEASE
    } env_state_e;

    env_state_e       state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [31:0]      phase_q, phase_d;
    logic [7:0]       amp_q, amp_d;
    logic             tick_q, tick_d;
    logic [7:0]       sample_q, sample_d;
    logic             valid_q, valid_d;
    logic [7:0]       pwm_cnt_q, pwm_cnt_d;
    logic             pwm_q, pwm_d;

    logic        tick;
    logic        note_on;
    logic [32:0] up_sum;
    logic [7:0]  amp_up;
    logic [7:0]  amp_dn;

    assign tick    = (div_cnt_q == DIV_LAST);
    assign note_on = (fstep_i != 32'd0);

    // Saturating envelope steps; widened so large step parameters cannot wrap.
    assign up_sum = 33'(amp_q) + 33'(ATTACK_STEP_P);
    assign amp_up = (up_sum > 33'd255) ? 8'hFF : up_sum[7:0];
    assign amp_dn = (32'(amp_q) > RELEASE_STEP_P)
                  ? (amp_q - 8'(RELEASE_STEP_P)) : 8'd0;

    always_comb begin
        state_d   = state_q;
        amp_d     = amp_q;
        phase_d   = phase_q;
        div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        tick_d    = tick;
        valid_d   = tick_q;
        sample_d  = sample_q;
        pwm_cnt_d = pwm_cnt_q + 8'd1;
        pwm_d     = (pwm_cnt_q < sample_q);

        // Sample is taken one edge after the tick edge, from the updated
        // phase and amplitude.
        if (tick_q) begin
            sample_d = phase_q[31] ? amp_q : 8'd0;
        end

        if (tick) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (note_on) begin
                        state_d = ST_ATTACK;
                        amp_d   = amp_up;
                    end
                end
                ST_ATTACK: begin
                    if (!note_on) begin
                        state_d = ST_RELEASE;
                        amp_d   = amp_dn;
                    end else begin
                        amp_d = amp_up;
                        if (amp_up == 8'hFF) begin
                            state_d = ST_SUSTAIN;
                        end
                    end
                end
                ST_SUSTAIN: begin
                    amp_d = 8'hFF;
                    if (!note_on) begin
                        state_d = ST_RELEASE;
                        amp_d   = amp_dn;
                    end
                end
                ST_RELEASE: begin
                    if (note_on) begin
                        state_d = ST_ATTACK;
                        amp_d   = amp_up;
                    end else begin
                        amp_d = amp_dn;
                        if (amp_dn == 8'd0) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    amp_d   = 8'd0;
                end
            endcase

            phase_d = (state_d == ST_IDLE) ? 32'd0 : phase_q + fstep_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= '0;
            phase_q   <= 32'd0;
            amp_q     <= 8'd0;
            tick_q    <= 1'b0;
            sample_q  <= 8'd0;
            valid_q   <= 1'b0;
            pwm_cnt_q <= 8'd0;
            pwm_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            phase_q   <= phase_d;
            amp_q     <= amp_d;
            tick_q    <= tick_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            pwm_cnt_q <= pwm_cnt_d;
            pwm_q     <= pwm_d;
        end
    end

    assign sample_o       = sample_q;
    assign sample_valid_o = valid_q;
    assign pwm_o          = pwm_q;
    assign active_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tone_synth.sv
// Testbench for tone_synth: directed note sequences plus random segments,
// compared cycle by cycle against an arithmetic envelope model.
module tb_tone_synth;

    localparam int DIV = 4;
    localparam int ATK = 4;
    localparam int REL = 2;

    logic        clk = 1'b0;
    logic        reset_i = 1'b0;
    logic [31:0] fstep_i = 32'd0;
    logic [7:0]  sample_o;
    logic        sample_valid_o;
    logic        pwm_o;
    logic        active_o;

    int checks = 0;
    int failures = 0;

    // Model state: the note is "sounding" while m_active; the amplitude
    // rises on note-on and decays on note-off until it reaches zero.
    int          m_div = 0;
    bit          m_tick_seen = 0;
    int          m_amp = 0;
    bit          m_active = 0;
    logic [31:0] m_phase = 0;
    int          m_sample = 0;
    bit          m_valid = 0;
    int          m_pwm_cnt = 0;
    bit          m_pwm = 0;

    tone_synth #(
        .SAMPLE_DIV_P(DIV),
        .ATTACK_STEP_P(ATK),
        .RELEASE_STEP_P(REL)
    ) dut (
        .clk_i(clk),
        .reset_i(reset_i),
        .fstep_i(fstep_i),
        .sample_o(sample_o),
        .sample_valid_o(sample_valid_o),
        .pwm_o(pwm_o),
        .active_o(active_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic [31:0] f, input logic r);
        int a;
        int o_sample;
        int o_amp;
        logic [31:0] o_phase;
        if (!r) begin
            m_div = 0; m_tick_seen = 0; m_amp = 0; m_active = 0;
            m_phase = 0; m_sample = 0; m_valid = 0;
            m_pwm_cnt = 0; m_pwm = 0;
        end else begin
            o_sample = m_sample;
            o_amp    = m_amp;
            o_phase  = m_phase;
            m_valid = m_tick_seen;
            if (m_tick_seen) m_sample = o_phase[31] ? o_amp : 0;
            m_pwm = (m_pwm_cnt < o_sample);
            m_pwm_cnt = (m_pwm_cnt + 1) % 256;
            m_tick_seen = (m_div == DIV - 1);
            m_div = (m_div + 1) % DIV;
            if (m_tick_seen) begin
                if (f != 0) begin
                    a = o_amp + ATK;
                    m_amp = (a > 255) ? 255 : a;
                    m_active = 1;
                end else if (m_active) begin
                    a = o_amp - REL;
                    m_amp = (a < 0) ? 0 : a;
                    m_active = (m_amp != 0);
                end
                m_phase = m_active ? o_phase + f : 32'd0;
            end
        end
    endtask

    task automatic cyc(input logic [31:0] f, input logic r);
        fstep_i = f;
        reset_i = r;
        @(posedge clk);
        model_edge(f, r);
        #1;
        chk("sample", 32'(sample_o), 32'(m_sample));
        chk("valid", 32'(sample_valid_o), 32'(m_valid));
        chk("pwm", 32'(pwm_o), 32'(m_pwm));
        chk("active", 32'(active_o), 32'(m_active));
    endtask

    task automatic ticks(input logic [31:0] f, input int n);
        repeat (n * DIV) cyc(f, 1'b1);
    endtask

    initial begin
        logic [31:0] f;
        int len;

        cyc(32'd0, 1'b0);
        cyc(32'd0, 1'b0);
        chk("rst_sample", 32'(sample_o), 32'd0);
        chk("rst_active", 32'(active_o), 32'd0);

        repeat (200) cyc(32'd0, 1'b1);
        chk("idle_active", 32'(active_o), 32'd0);

        ticks(32'h4000_0000, 70);
        chk("sustain_active", 32'(active_o), 32'd1);
        ticks(32'hC000_0000, 12);
        ticks(32'd0, 10);
        ticks(32'h1000_0000, 20);
        chk("reattack_active", 32'(active_o), 32'd1);
        ticks(32'h4000_0000, 70);
        ticks(32'd0, 140);
        chk("released_active", 32'(active_o), 32'd0);

        ticks(32'h0800_0000, 5);
        cyc(32'h0800_0000, 1'b0);
        chk("midrst_sample", 32'(sample_o), 32'd0);
        chk("midrst_valid", 32'(sample_valid_o), 32'd0);
        chk("midrst_pwm", 32'(pwm_o), 32'd0);
        chk("midrst_active", 32'(active_o), 32'd0);

        for (int s = 0; s < 30; s++) begin
            f = ($urandom_range(0, 2) == 0) ? 32'd0 : $urandom;
            len = $urandom_range(1, 40);
            for (int c = 0; c < len * DIV; c++) begin
                cyc(f, ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
